// File: rtl/uart_pkg.sv
// uart_pkg: shared types and default constants for the UART receive/transmit pair.
//   uart_rx_state_t   receiver FSM state encoding
//   DEFAULT_CLK_FREQ  system clock frequency in Hz; uart_tx uses the same baud plan
//   DEFAULT_UART_BPS  line baud rate
//   UART_DATA_BITS    payload bits per frame (8N1)
package uart_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_UART_BPS = 115_200;
  localparam int UART_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs.
//   clk_i  in   1      destination clock
//   rst_n  in   1      asynchronous reset, active-low; both flops load RST_VAL
//   d      in   WIDTH  asynchronous input
//   q      out  WIDTH  synchronised output, two clk_i cycles of latency
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= RST_VAL;
      q        <= RST_VAL;
    end else begin
      meta_reg <= d;
      q        <= meta_reg;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with start-bit qualification, 3-sample majority vote
// at mid-bit and framing-error detection.
//   clk_i         in   1  system clock
//   rst_n         in   1  asynchronous reset, active-low
//   uart_rxd      in   1  serial input, asynchronous, idle high
//   rx_data       out  8  last good byte, LSB received first
//   rx_valid      out  1  one-cycle pulse: rx_data updated this cycle
//   rx_frame_err  out  1  one-cycle pulse: stop bit sampled low
//   rx_busy       out  1  high from start-bit detect until return to idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = DEFAULT_CLK_FREQ,
  parameter int UART_BPS = DEFAULT_UART_BPS
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int BAUD_MID     = BAUD_CNT_MAX / 2;

  localparam logic [15:0] CNT_LAST = 16'(BAUD_CNT_MAX - 1);
  localparam logic [15:0] SMP_A    = 16'(BAUD_MID - 1);
  localparam logic [15:0] SMP_B    = 16'(BAUD_MID);
  localparam logic [15:0] DECIDE   = 16'(BAUD_MID + 1);

  generate
    if (BAUD_CNT_MAX < 16 || BAUD_CNT_MAX > 65535) begin : g_bad_baud
      $error("uart_rx: CLK_FREQ/UART_BPS = %0d is outside 16..65535", BAUD_CNT_MAX);
    end
  endgenerate

  // Input path: synchroniser idles high so reset never fakes a start edge,
  // third flop gives the previous synced value for edge detection.
  logic rxd_sync;
  logic rxd_prev_reg;
  logic fall_edge;

  sync_2ff #(
    .WIDTH  (1),
    .RST_VAL(1'b1)
  ) u_sync_rxd (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .d    (uart_rxd),
    .q    (rxd_sync)
  );

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rxd_prev_reg <= 1'b1;
    end else begin
      rxd_prev_reg <= rxd_sync;
    end
  end

  assign fall_edge = rxd_prev_reg & ~rxd_sync;

  uart_rx_state_t state_reg, state_next;
  logic [15:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic [1:0]  smp_reg, smp_next;
  logic [7:0]  rx_data_reg, rx_data_next;
  logic        rx_valid_reg, rx_valid_next;
  logic        rx_frame_err_reg, rx_frame_err_next;
  logic        rx_busy_reg, rx_busy_next;
  logic        decide;
  logic        vote;

  // The two earlier samples are held in smp_reg; the third is the live synced
  // line on the decision cycle, so the vote is ready exactly at BAUD_MID+1.
  assign decide = (baud_cnt_reg == DECIDE);
  assign vote   = (smp_reg[0] & smp_reg[1]) | (smp_reg[0] & rxd_sync) | (smp_reg[1] & rxd_sync);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= RX_IDLE;
      baud_cnt_reg     <= '0;
      bit_cnt_reg      <= '0;
      shift_reg        <= '0;
      smp_reg          <= 2'b11;
      rx_data_reg      <= 8'h00;
      rx_valid_reg     <= 1'b0;
      rx_frame_err_reg <= 1'b0;
      rx_busy_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      baud_cnt_reg     <= baud_cnt_next;
      bit_cnt_reg      <= bit_cnt_next;
      shift_reg        <= shift_next;
      smp_reg          <= smp_next;
      rx_data_reg      <= rx_data_next;
      rx_valid_reg     <= rx_valid_next;
      rx_frame_err_reg <= rx_frame_err_next;
      rx_busy_reg      <= rx_busy_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    baud_cnt_next     = (baud_cnt_reg == CNT_LAST) ? 16'd0 : baud_cnt_reg + 16'd1;
    bit_cnt_next      = bit_cnt_reg;
    shift_next        = shift_reg;
    smp_next          = smp_reg;
    rx_data_next      = rx_data_reg;
    rx_valid_next     = 1'b0;
    rx_frame_err_next = 1'b0;

    if (baud_cnt_reg == SMP_A) smp_next[0] = rxd_sync;
    if (baud_cnt_reg == SMP_B) smp_next[1] = rxd_sync;

    case (state_reg)
      RX_IDLE: begin
        // Counter parked at zero so START begins a fresh bit period.
        baud_cnt_next = '0;
        if (fall_edge) state_next = RX_START;
      end
      RX_START: begin
        if (decide) begin
          if (!vote) begin
            state_next   = RX_DATA;
            bit_cnt_next = '0;
          end else begin
            state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (decide) begin
          shift_next   = {vote, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 3'd1;
          if (bit_cnt_reg == 3'(UART_DATA_BITS - 1)) state_next = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at mid-stop lets a following start bit arrive early.
        if (decide) begin
          if (vote) begin
            rx_data_next  = shift_reg;
            rx_valid_next = 1'b1;
            state_next    = RX_IDLE;
          end else begin
            rx_frame_err_next = 1'b1;
            state_next        = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // A line held low must go high again before a new start is accepted.
        baud_cnt_next = '0;
        if (rxd_sync) state_next = RX_IDLE;
      end
      default: begin
        state_next = RX_IDLE;
      end
    endcase

    rx_busy_next = (state_next == RX_START) || (state_next == RX_DATA) || (state_next == RX_STOP);
  end

  assign rx_data      = rx_data_reg;
  assign rx_valid     = rx_valid_reg;
  assign rx_frame_err = rx_frame_err_reg;
  assign rx_busy      = rx_busy_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. The receiver runs at 2 Mbaud
// (50 clocks per bit) so every scenario, including the loopback sweep with
// +/-2% baud skew, fits in a short run; the logic is identical to 115200.
module tb_uart_rx;

  localparam int CLK_FREQ = 100_000_000;
  localparam int UART_BPS = 2_000_000;
  localparam int B        = CLK_FREQ / UART_BPS;

  logic       clk_i    = 1'b0;
  logic       rst_n    = 1'b0;
  logic       uart_rxd = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;

  int n_cmp = 0;
  int n_bad = 0;

  // {frame_err, data}
  logic [8:0] exp_q[$];
  logic [8:0] obs_q[$];

  logic prev_valid = 1'b0;
  logic prev_err   = 1'b0;

  always #5 clk_i = ~clk_i;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ),
    .UART_BPS(UART_BPS)
  ) dut (
    .clk_i       (clk_i),
    .rst_n       (rst_n),
    .uart_rxd    (uart_rxd),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_frame_err(rx_frame_err),
    .rx_busy     (rx_busy)
  );

  // Strobe monitor: records every output event and checks the strobe rules.
  always @(negedge clk_i) begin
    if (rst_n && (rx_valid || rx_frame_err)) begin
      n_cmp++;
      if (rx_valid && rx_frame_err) begin
        n_bad++;
        $display("FAIL strobe_exclusive: valid=%b frame_err=%b, required not both high", rx_valid, rx_frame_err);
      end
      n_cmp++;
      if (rx_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL busy_at_strobe: rx_busy=%b, required 0", rx_busy);
      end
      n_cmp++;
      if ((rx_valid && prev_valid) || (rx_frame_err && prev_err)) begin
        n_bad++;
        $display("FAIL strobe_width: strobe high 2 cycles, required 1");
      end
      obs_q.push_back({rx_frame_err, rx_data});
      $display("event: frame_err=%b data=%h", rx_frame_err, rx_data);
    end
    prev_valid <= rx_valid;
    prev_err   <= rx_frame_err;
  end

  // Drives one frame; leaves the line at the stop value.
  task automatic send_frame(input logic [7:0] b, input int bit_clks, input int stop_clks, input logic stop_val);
    uart_rxd = 1'b0;
    repeat (bit_clks) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (bit_clks) @(negedge clk_i);
    end
    uart_rxd = stop_val;
    repeat (stop_clks) @(negedge clk_i);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (obs_q.size() >= n) break;
      @(negedge clk_i);
    end
    if (obs_q.size() >= n) ok = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: rx_data=%h, required 00", rx_data); end
    n_cmp++;
    if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: rx_valid=%b, required 0", rx_valid); end
    n_cmp++;
    if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: rx_frame_err=%b, required 0", rx_frame_err); end
    n_cmp++;
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: rx_busy=%b, required 0", rx_busy); end
    rst_n = 1'b1;
    repeat (10) @(negedge clk_i);
  endtask

  task automatic test_single();
    logic [8:0] e, o;
    bit ok;
    exp_q.push_back({1'b0, 8'h55});
    send_frame(8'h55, B, B, 1'b1);
    wait_obs(1, 4 * B, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL single_timeout: strobes=%0d, required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL single_byte: err=%b data=%h, required err=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
    end
    exp_q.delete();
    n_cmp++;
    if (rx_data !== 8'h55) begin n_bad++; $display("FAIL single_hold: rx_data=%h, required 55", rx_data); end
    repeat (2 * B) @(negedge clk_i);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL single_extra: extra strobes=%0d, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [8:0] e, o;
    bit ok;
    exp_q.push_back({1'b0, 8'hA5});
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'hA5, B, (B * 15 + 15) / 16, 1'b1);
    send_frame(8'h3C, B, B, 1'b1);
    wait_obs(2, 4 * B, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL b2b_timeout: strobes=%0d, required 2", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL b2b_byte: err=%b data=%h, required err=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
    end
    exp_q.delete();
    obs_q.delete();
    repeat (B) @(negedge clk_i);
  endtask

  task automatic test_glitch();
    bit busy_seen;
    busy_seen = 1'b0;
    uart_rxd  = 1'b0;
    repeat (20) begin
      @(negedge clk_i);
      if (rx_busy) busy_seen = 1'b1;
    end
    uart_rxd = 1'b1;
    repeat (10) begin
      @(negedge clk_i);
      if (rx_busy) busy_seen = 1'b1;
    end
    repeat (3 * B) @(negedge clk_i);
    n_cmp++;
    if (busy_seen !== 1'b1) begin n_bad++; $display("FAIL glitch_busy_pulse: busy seen=%b, required 1", busy_seen); end
    n_cmp++;
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL glitch_busy_end: rx_busy=%b, required 0", rx_busy); end
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL glitch_strobe: strobes=%0d, required 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    logic [8:0] e, o;
    bit ok;
    exp_q.push_back({1'b1, 8'h3C});
    send_frame(8'hF0, B, B, 1'b0);
    repeat (B + B / 2) @(negedge clk_i);
    n_cmp++;
    if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL break_busy: rx_busy=%b, required 0", rx_busy); end
    repeat (B + B / 2) @(negedge clk_i);
    uart_rxd = 1'b1;
    repeat (2 * B) @(negedge clk_i);
    wait_obs(1, 4 * B, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL ferr_timeout: strobes=%0d, required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL ferr_event: err=%b data=%h, required err=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
    end
    exp_q.delete();
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL ferr_extra: extra strobes=%0d, required 0", obs_q.size()); end
    obs_q.delete();
    n_cmp++;
    if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ferr_data_hold: rx_data=%h, required 3c", rx_data); end
  endtask

  task automatic test_reset_midframe();
    logic [8:0] e, o;
    bit ok;
    fork
      send_frame(8'h81, B, B, 1'b1);
      begin
        repeat (5 * B + B / 2) @(negedge clk_i);
        rst_n = 1'b0;
        repeat (2) @(negedge clk_i);
        n_cmp++;
        if (rx_data !== 8'h00) begin n_bad++; $display("FAIL midreset_data: rx_data=%h, required 00", rx_data); end
        n_cmp++;
        if (rx_busy !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: rx_busy=%b, required 0", rx_busy); end
        repeat (4 * B - 2) @(negedge clk_i);
        rst_n = 1'b1;
      end
    join
    repeat (2 * B) @(negedge clk_i);
    n_cmp++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL midreset_strobe: strobes=%0d, required 0", obs_q.size()); end
    obs_q.delete();
    exp_q.push_back({1'b0, 8'h7E});
    send_frame(8'h7E, B, B, 1'b1);
    wait_obs(1, 4 * B, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL after_reset_timeout: strobes=%0d, required 1", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin n_bad++; $display("FAIL after_reset_byte: err=%b data=%h, required err=%b data=%h", o[8], o[7:0], e[8], e[7:0]); end
    end
    exp_q.delete();
    obs_q.delete();
    n_cmp++;
    if (rx_data !== 8'h7E) begin n_bad++; $display("FAIL after_reset_data: rx_data=%h, required 7e", rx_data); end
  endtask

  // Transmitter model feeding the receiver: nominal baud, then +2% and -2% bit periods.
  task automatic test_loopback();
    logic [8:0] e, o;
    logic [7:0] b;
    bit ok;
    int bit_clks;
    int count;
    for (int s = 0; s < 3; s++) begin
      bit_clks = (s == 0) ? B : ((s == 1) ? B + 1 : B - 1);
      count    = (s == 0) ? 66 : 16;
      for (int i = 0; i < count; i++) begin
        if (s == 0 && i == 0)      b = 8'h00;
        else if (s == 0 && i == 1) b = 8'hFF;
        else                       b = 8'($urandom_range(0, 255));
        exp_q.push_back({1'b0, b});
        send_frame(b, bit_clks, bit_clks, 1'b1);
        repeat (2) @(negedge clk_i);
        wait_obs(1, 4 * B, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL loop_timeout: skew=%0d idx=%0d strobes=%0d, required 1", s, i, obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
          e = exp_q.pop_front();
          o = obs_q.pop_front();
          n_cmp++;
          if (o !== e) begin n_bad++; $display("FAIL loop_byte: skew=%0d idx=%0d err=%b data=%h, required err=%b data=%h", s, i, o[8], o[7:0], e[8], e[7:0]); end
        end
        exp_q.delete();
        obs_q.delete();
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_midframe();
    test_loopback();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    repeat (150_000) @(posedge clk_i);
    $display("FAIL watchdog: run exceeded 150000 cycles, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
